// File: rtl/router_pkt_source.sv
// Packet source: header {len,addr}, len payload bytes, XOR parity; ROUTER_PARITY_CORRUPT_EN adds corrupt_parity.
// Latency: header on dout the edge after start, done L+2 edges later; busy freezes the byte stream.
module router_pkt_source (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic [7:0] pay_data,
  input  logic       busy,
  output logic       pay_ack,
  output logic       packet_valid,
  output logic [7:0] dout,
  output logic       done,
  output logic       cfg_err,
  output logic       in_idle
`ifdef ROUTER_PARITY_CORRUPT_EN
  ,
  input  logic       corrupt_parity
`endif
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_e;

  state_e     state_q, state_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] parity_q, parity_d;
  logic [5:0] rem_q, rem_d;
  logic       pv_q, pv_d;
  logic       done_q, done_d;
  logic       cfg_err_q, cfg_err_d;
  logic       corrupt_w;
  logic [7:0] hdr_w;

`ifdef ROUTER_PARITY_CORRUPT_EN
  assign corrupt_w = corrupt_parity;
`else
  assign corrupt_w = 1'b0;
`endif

  assign hdr_w = {pay_len, dest_addr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dout_q    <= 8'd0;
      parity_q  <= 8'd0;
      rem_q     <= 6'd0;
      pv_q      <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      parity_q  <= parity_d;
      rem_q     <= rem_d;
      pv_q      <= pv_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    parity_d  = parity_q;
    rem_d     = rem_q;
    pv_d      = pv_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (dest_addr != 2'd3 && pay_len != 6'd0) begin
            dout_d   = hdr_w;
            parity_d = hdr_w;
            rem_d    = pay_len;
            pv_d     = 1'b1;
            state_d  = HEADER;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      HEADER, PAYLOAD: begin
        if (!busy) begin
          if (rem_q != 6'd0) begin
            dout_d   = pay_data;
            parity_d = parity_q ^ pay_data;
            rem_d    = rem_q - 6'd1;
            state_d  = PAYLOAD;
          end else begin
            // Payload exhausted: the accumulated parity goes out unflagged.
            dout_d  = parity_q ^ {7'd0, corrupt_w};
            pv_d    = 1'b0;
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          dout_d  = 8'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pay_ack      = (state_q == HEADER || state_q == PAYLOAD) && !busy && (rem_q != 6'd0);
  assign packet_valid = pv_q;
  assign dout         = dout_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign in_idle      = (state_q == IDLE);

endmodule

// File: tb/tb_router_pkt_source.sv
// Bench for router_pkt_source: vector table, directed corner sequences, then randomized traffic vs a stream model.
module tb_router_pkt_source;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] pay_len = 6'd0;
  logic [7:0] pay_data = 8'd0;
  logic       busy = 1'b0;
  logic       pay_ack, packet_valid, done, cfg_err, in_idle;
  logic [7:0] dout;
`ifdef ROUTER_PARITY_CORRUPT_EN
  logic       corrupt = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_pkt_source dut (
    .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
    .pay_data(pay_data), .busy(busy), .pay_ack(pay_ack), .packet_valid(packet_valid),
    .dout(dout), .done(done), .cfg_err(cfg_err), .in_idle(in_idle)
`ifdef ROUTER_PARITY_CORRUPT_EN
    , .corrupt_parity(corrupt)
`endif
  );

  typedef struct {
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic [7:0] pd;
    logic       busy;
    logic       ack;
    logic       idle;
    logic [7:0] dout;
    logic       pv;
    logic       done;
    logic       cfg;
  } vec_t;

  function automatic vec_t v(input logic s, input logic [1:0] a, input logic [5:0] l,
                             input logic [7:0] pd, input logic b, input logic ack,
                             input logic idle, input logic [7:0] d, input logic pv,
                             input logic dn, input logic cf);
    vec_t r;
    r.start = s; r.addr = a; r.len = l; r.pd = pd; r.busy = b;
    r.ack = ack; r.idle = idle; r.dout = d; r.pv = pv; r.done = dn; r.cfg = cf;
    return r;
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] a, input logic [5:0] l,
                       input logic [7:0] pd, input logic b);
    start = s; dest_addr = a; pay_len = l; pay_data = pd; busy = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t             tbl[$];
    bit               m_active;
    int               m_pos, m_len;
    logic [7:0]       m_stream[$];
    logic [7:0]       m_pay[$];
    logic [7:0]       m_dout, par;
    logic             m_pv, e_done, e_cfg;
    logic             s_r, b_r;
    logic [1:0]       a_r;
    logic [5:0]       l_r;

    // addr=1 len=3 payload 11,22,33 without stalls
    tbl.push_back(v(1, 1, 3, 8'h00, 0, 0, 1, 8'h0D, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h11, 0, 1, 0, 8'h11, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h22, 0, 1, 0, 8'h22, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h33, 0, 1, 0, 8'h33, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 8'h0D, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0));
    // same packet, two busy cycles on byte 22 and an ignored start mid-packet
    tbl.push_back(v(1, 1, 3, 8'h00, 0, 0, 1, 8'h0D, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h11, 0, 1, 0, 8'h11, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h22, 0, 1, 0, 8'h22, 1, 0, 0));
    tbl.push_back(v(1, 0, 5, 8'h33, 1, 0, 0, 8'h22, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h33, 1, 0, 0, 8'h22, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h33, 0, 1, 0, 8'h33, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 8'h0D, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0));
    // illegal starts: len=0, then addr=3
    tbl.push_back(v(1, 1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1));
    tbl.push_back(v(1, 3, 5, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0));

    #1 rst = 1'b0;
    #1;
    chk8("rst_dout", dout, 8'h00);
    chk1("rst_pv", packet_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_cfg", cfg_err, 1'b0);
    chk1("rst_idle", in_idle, 1'b1);
    chk1("rst_ack", pay_ack, 1'b0);
    #10 rst = 1'b1;
    tick;

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].addr, tbl[i].len, tbl[i].pd, tbl[i].busy);
      #1;
      chk1($sformatf("tbl%0d_ack", i), pay_ack, tbl[i].ack);
      chk1($sformatf("tbl%0d_idle", i), in_idle, tbl[i].idle);
      tick;
      chk8($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
      chk1($sformatf("tbl%0d_pv", i), packet_valid, tbl[i].pv);
      chk1($sformatf("tbl%0d_done", i), done, tbl[i].done);
      chk1($sformatf("tbl%0d_cfg", i), cfg_err, tbl[i].cfg);
    end

    // Maximum length: 63 bytes of A5, done on the 65th edge after start
    drive(1, 2, 63, 8'h00, 0);
    tick;
    chk8("max_hdr", dout, 8'hFE);
    chk1("max_hdr_pv", packet_valid, 1'b1);
    for (int k = 0; k < 63; k++) begin
      drive(0, 0, 0, 8'hA5, 0);
      #1;
      chk1($sformatf("max_ack%0d", k), pay_ack, 1'b1);
      tick;
      chk8($sformatf("max_pay%0d", k), dout, 8'hA5);
      chk1($sformatf("max_pv%0d", k), packet_valid, 1'b1);
    end
    drive(0, 0, 0, 8'h00, 0);
    #1;
    chk1("max_ack_end", pay_ack, 1'b0);
    tick;
    chk8("max_par", dout, 8'h5B);
    chk1("max_par_pv", packet_valid, 1'b0);
    chk1("max_par_done", done, 1'b0);
    tick;
    chk1("max_done", done, 1'b1);
    chk8("max_done_dout", dout, 8'h00);

    // Asynchronous reset while the second payload byte is on dout
    drive(1, 1, 3, 8'h00, 0);
    tick;
    drive(0, 0, 0, 8'h11, 0);
    tick;
    drive(0, 0, 0, 8'h22, 0);
    tick;
    chk8("mid_byte2", dout, 8'h22);
    #2 rst = 1'b0;
    drive(1, 0, 1, 8'h00, 0);
    #1;
    chk8("arst_dout", dout, 8'h00);
    chk1("arst_pv", packet_valid, 1'b0);
    chk1("arst_idle", in_idle, 1'b1);
    #3 rst = 1'b1;
    tick;
    chk8("post_rst_hdr", dout, 8'h04);
    chk1("post_rst_pv", packet_valid, 1'b1);
    drive(0, 0, 0, 8'h7E, 0);
    #1;
    chk1("post_rst_ack", pay_ack, 1'b1);
    tick;
    chk8("post_rst_pay", dout, 8'h7E);
    drive(0, 0, 0, 8'h00, 0);
    tick;
    chk8("post_rst_par", dout, 8'h7A);
    tick;
    chk1("post_rst_done", done, 1'b1);

`ifdef ROUTER_PARITY_CORRUPT_EN
    drive(1, 1, 3, 8'h00, 0);
    tick;
    drive(0, 0, 0, 8'h11, 0);
    tick;
    drive(0, 0, 0, 8'h22, 0);
    tick;
    drive(0, 0, 0, 8'h33, 0);
    tick;
    corrupt = 1'b1;
    drive(0, 0, 0, 8'h00, 0);
    tick;
    chk8("corrupt_par", dout, 8'h0C);
    chk1("corrupt_pv", packet_valid, 1'b0);
    corrupt = 1'b0;
    tick;
    chk1("corrupt_done", done, 1'b1);
`endif

    // Randomized traffic: the model tracks the position within the expected byte stream
    m_active = 1'b0; m_pos = 0; m_len = 0; m_dout = 8'h00; m_pv = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      s_r = ($urandom % 3 == 0);
      a_r = 2'($urandom % 4);
      if ($urandom % 8 == 0) l_r = 6'd0;
      else if ($urandom % 6 == 0) l_r = 6'($urandom_range(1, 63));
      else l_r = 6'($urandom_range(1, 5));
      b_r = ($urandom % 4 == 0);
      drive(s_r, a_r, l_r, (m_active && m_pos < m_len) ? m_pay[m_pos] : 8'($urandom), b_r);
      #1;
      chk1("rnd_ack", pay_ack, m_active && !b_r && (m_pos < m_len));
      chk1("rnd_idle", in_idle, !m_active);
      e_done = 1'b0;
      e_cfg  = 1'b0;
      if (!m_active) begin
        if (s_r) begin
          if (a_r != 2'd3 && l_r != 6'd0) begin
            m_len = int'(l_r);
            m_pay.delete();
            m_stream.delete();
            par = {l_r, a_r};
            m_stream.push_back(par);
            for (int k = 0; k < m_len; k++) begin
              m_pay.push_back(8'($urandom));
              m_stream.push_back(m_pay[k]);
              par = par ^ m_pay[k];
            end
            m_stream.push_back(par);
            m_active = 1'b1;
            m_pos    = 0;
            m_dout   = m_stream[0];
            m_pv     = 1'b1;
          end else begin
            e_cfg = 1'b1;
          end
        end
      end else if (!b_r) begin
        m_pos++;
        if (m_pos == m_len + 2) begin
          m_active = 1'b0;
          m_dout   = 8'h00;
          m_pv     = 1'b0;
          e_done   = 1'b1;
        end else begin
          m_dout = m_stream[m_pos];
          m_pv   = (m_pos <= m_len);
        end
      end
      tick;
      chk8("rnd_dout", dout, m_dout);
      chk1("rnd_pv", packet_valid, m_pv);
      chk1("rnd_done", done, e_done);
      chk1("rnd_cfg", cfg_err, e_cfg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_pkt_source.md
ROUTER_PKT_SOURCE -- requirements
Module: router_pkt_source

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  request to send one packet, sampled only in IDLE.
REQ-004 SHALL have port dest_addr  input  2  destination port 0..2; 3 is illegal.
REQ-005 SHALL have port pay_len  input  6  payload byte count 1..63; 0 is illegal.
REQ-006 SHALL have port pay_data  input  8  next payload byte from the upstream source.
REQ-007 SHALL have port busy  input  1  router stall; while high, the current byte is not transferred.
REQ-008 SHALL have port pay_ack  output  1  combinational; high in a cycle where pay_data is consumed.
REQ-009 SHALL have port packet_valid  output  1  registered; high for header and payload bytes, low for the parity byte.
REQ-010 SHALL have port dout  output  8  registered packet byte to the router.
REQ-011 SHALL have port done  output  1  registered one-cycle pulse after the parity byte is transferred.
REQ-012 SHALL have port cfg_err  output  1  registered one-cycle pulse when start is rejected.
REQ-013 SHALL have port in_idle  output  1  high when the FSM is in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, HEADER, PAYLOAD and PARITY.
REQ-015 SHALL accept start in IDLE only if dest_addr!=3 and pay_len!=0: at that edge, dout<={pay_len,dest_addr}, packet_valid<=1, parity<={pay_len,dest_addr}, remaining<=pay_len, FSM to HEADER.
REQ-016 SHALL treat an illegal start in IDLE as follows: stay in IDLE, cfg_err=1 for one cycle, dout and packet_valid unchanged.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL define transfer as: the byte on dout is transferred at any rising edge in HEADER, PAYLOAD or PARITY where busy==0.
REQ-019 SHALL, while busy==1, hold dout, packet_valid, parity, remaining and state, and keep pay_ack=0.
REQ-020 SHALL set pay_ack = (HEADER or PAYLOAD) & !busy & (remaining!=0).
REQ-021 SHALL, on a transfer where remaining!=0, do all of: dout<=pay_data, parity<=parity^pay_data, remaining<=remaining-1, FSM to PAYLOAD.
REQ-022 SHALL, on a transfer in PAYLOAD where remaining==0, do all of: dout<=parity, packet_valid<=0, FSM to PARITY.
REQ-023 SHALL, on a transfer in PARITY, do all of: dout<=0, done<=1 for one cycle, FSM to IDLE; a start in the following IDLE cycle is accepted, with no extra gap.
REQ-024 SHALL complete a packet of length L with no busy in L+2 cycles from the start edge to done assertion.
REQ-025 SHALL hold remaining in 6 bits; pay_len=63 SHALL produce exactly 63 payload bytes with no wrap.

Reset
REQ-026 SHALL, on rst low, immediately force all of: FSM=IDLE, dout=0, packet_valid=0, done=0, cfg_err=0, parity=0, remaining=0, independent of clk.
REQ-027 SHALL abandon any packet in progress when rst asserts mid-packet, and SHALL NOT resume it after reset.
REQ-028 SHALL treat the first edge after rst deasserts as normal IDLE operation.

Configuration
REQ-029 SHALL, with macro ROUTER_PARITY_CORRUPT_EN defined, add input corrupt_parity (1 bit), sampled at the REQ-022 edge; when 1, the parity byte driven is parity^8'h01.
REQ-030 SHALL, without ROUTER_PARITY_CORRUPT_EN, have no corrupt_parity port and always drive the true parity.

Verification
REQ-031 SHALL verify: start, addr=1, len=3, payload 11,22,33, busy=0 -> dout sequence 0D,11,22,33,0D; packet_valid 1,1,1,1,0; done pulse on cycle 5 after start.
REQ-032 SHALL verify: same packet with busy=1 for 2 cycles during byte 22 -> 22 held 3 cycles, pay_ack low while busy, same final parity 0D.
REQ-033 SHALL verify: start with len=0, then start with addr=3 -> cfg_err pulse for each, in_idle stays 1, packet_valid stays 0.
REQ-034 SHALL verify: addr=2, len=63, payload all A5 -> header FE, 63 payload bytes, parity FE^A5=5B, done after 65 cycles.
REQ-035 SHALL verify: rst low during the 2nd payload byte -> dout=0 and packet_valid=0 immediately; next start emits a fresh header.
REQ-036 SHALL verify, with ROUTER_PARITY_CORRUPT_EN defined: first packet with corrupt_parity=1 -> parity byte 0C.
